// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the lsu_memdados load/store unit:
//   - DATA_W            : data and address width
//   - MEM_WORDS_DEFAULT : default number of words in the data memory
//   - SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL : req_size encodings
//   - lsu_state_e       : controller FSM state encoding
// Ports: none (package).
// Configuration macro honoured by the users of this package: LSU_SUBWORD_EN
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam int DATA_W            = 32;
  localparam int MEM_WORDS_DEFAULT = 64;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_memdados_if.sv
// ---------------------------------------------------------------------------
// lsu_memdados_if
// Bundles the request/response handshake towards the datapath and the word
// port towards the data memory.
//   Request : req_valid, req_ready, req_write, req_size, req_unsigned,
//             req_addr, req_wdata
//   Response: resp_valid, resp_rdata, resp_err
//   Memory  : mem_read, mem_write, mem_posicao, mem_dados, mem_saida
// Modports:
//   slave  - the load/store unit
//   master - the environment (datapath driver plus data memory)
// ---------------------------------------------------------------------------
interface lsu_memdados_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_posicao;
  logic [DATA_W-1:0] mem_dados;
  logic [DATA_W-1:0] mem_saida;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_saida,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_posicao, mem_dados
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_saida,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_posicao, mem_dados
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// ---------------------------------------------------------------------------
// lsu_byte_lane
// Purely combinational lane logic for sub-word accesses (little-endian).
// Ports:
//   size_i       in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   offs_i       in  2   byte offset inside the word (addr[1:0])
//   unsigned_i   in  1   zero-extend loads instead of sign-extending
//   load_word_i  in  32  word read from memory, source for load extraction
//   old_word_i   in  32  previously captured word, base for the store merge
//   store_data_i in  32  right-aligned store data
//   merged_o     out 32  old word with the addressed lane(s) replaced
//   load_data_o  out 32  extracted and extended load data
// Only instantiated when LSU_SUBWORD_EN is defined.
// ---------------------------------------------------------------------------
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        offs_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] load_word_i,
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic [DATA_W-1:0] merged_o,
  output logic [DATA_W-1:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store merge: start from the old word and overwrite only the addressed lane.
  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: begin
        case (offs_i)
          2'd0:    merged_o[7:0]   = store_data_i[7:0];
          2'd1:    merged_o[15:8]  = store_data_i[7:0];
          2'd2:    merged_o[23:16] = store_data_i[7:0];
          default: merged_o[31:24] = store_data_i[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offs_i[1]) merged_o[31:16] = store_data_i[15:0];
        else           merged_o[15:0]  = store_data_i[15:0];
      end
      default: merged_o = store_data_i;
    endcase
  end

  // Load extract: pick the lane by offset, then sign- or zero-extend.
  always_comb begin
    case (offs_i)
      2'd0:    byte_sel = load_word_i[7:0];
      2'd1:    byte_sel = load_word_i[15:8];
      2'd2:    byte_sel = load_word_i[23:16];
      default: byte_sel = load_word_i[31:24];
    endcase
    half_sel = offs_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    case (size_i)
      SZ_BYTE: load_data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SZ_HALF: load_data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_memdados.sv
// ---------------------------------------------------------------------------
// lsu_memdados
// Load/store unit between the datapath and a word-organised data memory
// (combinational read, write on the clock edge). Accepts one byte-addressed
// request at a time, converts it to word-indexed accesses, performs sub-word
// stores as read-modify-write, and returns a one-cycle response.
// Ports:
//   clk    in  1   clock, rising edge
//   reset  in  1   asynchronous, active-high reset
//   bus    slave modport of lsu_memdados_if (request, response, memory port)
// Parameters:
//   MEM_WORDS  number of memory words; word indices at or above are rejected
// Configuration macro: LSU_SUBWORD_EN
//   defined   - byte and half accesses supported (READ->WRITE merge path)
//   undefined - only word accesses; any other size answers with resp_err
// ---------------------------------------------------------------------------
module lsu_memdados
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
)
(
  input  logic           clk,
  input  logic           reset,
  lsu_memdados_if.slave  bus
);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] posicao_q, posicao_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              acc_err;
  logic              idx_oob;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

  // Word index is checked against the live request so the decision is
  // made in the accept cycle.
  assign idx_oob = (bus.req_addr >> 2) >= 32'(MEM_WORDS);

`ifdef LSU_SUBWORD_EN
  logic [1:0]        size_q, size_d;
  logic [1:0]        offs_q, offs_d;
  logic              unsigned_q, unsigned_d;
  logic [DATA_W-1:0] rdword_q, rdword_d;

  // Lane logic: extraction works on the live memory word during READ,
  // the merge works on the word captured at the end of READ.
  lsu_byte_lane u_lane (
    .size_i       (size_q),
    .offs_i       (offs_q),
    .unsigned_i   (unsigned_q),
    .load_word_i  (bus.mem_saida),
    .old_word_i   (rdword_q),
    .store_data_i (wdata_q),
    .merged_o     (store_word),
    .load_data_o  (load_data)
  );

  assign acc_err = (bus.req_size == SZ_ILLEGAL)
                 | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                 | ((bus.req_size == SZ_WORD) & (bus.req_addr[1:0] != 2'b00))
                 | idx_oob;
`else
  assign load_data  = bus.mem_saida;
  assign store_word = wdata_q;

  assign acc_err = (bus.req_size != SZ_WORD)
                 | (bus.req_addr[1:0] != 2'b00)
                 | idx_oob;
`endif

  // State and captured-request registers; async reset discards any request
  // in flight, which also drops the memory strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      posicao_q    <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef LSU_SUBWORD_EN
      size_q       <= SZ_WORD;
      offs_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      rdword_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      posicao_q    <= posicao_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef LSU_SUBWORD_EN
      size_q       <= size_d;
      offs_q       <= offs_d;
      unsigned_q   <= unsigned_d;
      rdword_q     <= rdword_d;
`endif
    end
  end

  // Next-state logic. Response registers only change when a response is
  // being prepared, so they hold between responses.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    posicao_d    = posicao_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef LSU_SUBWORD_EN
    size_d       = size_q;
    offs_d       = offs_q;
    unsigned_d   = unsigned_q;
    rdword_d     = rdword_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d   = bus.req_write;
          posicao_d = bus.req_addr >> 2;
          wdata_d   = bus.req_wdata;
`ifdef LSU_SUBWORD_EN
          size_d     = bus.req_size;
          offs_d     = bus.req_addr[1:0];
          unsigned_d = bus.req_unsigned;
`endif
          if (acc_err) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
            state_d = WRITE;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d = READ;
          end
        end
      end
      READ: begin
`ifdef LSU_SUBWORD_EN
        rdword_d = bus.mem_saida;
        if (write_q) begin
          state_d = WRITE;
        end else begin
          state_d      = RESP;
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
        end
`else
        state_d      = RESP;
        resp_rdata_d = load_data;
        resp_err_d   = 1'b0;
`endif
      end
      WRITE: begin
        state_d      = RESP;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register; strobes are mutually exclusive.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.mem_read    = (state_q == READ);
  assign bus.mem_write   = (state_q == WRITE);
  assign bus.mem_posicao = posicao_q;
  assign bus.mem_dados   = (state_q == WRITE) ? store_word : '0;

endmodule

// File: tb/tb_lsu_memdados.sv
// ---------------------------------------------------------------------------
// tb_lsu_memdados
// Self-checking bench for lsu_memdados: a behavioural data memory, a
// reference memory model and a scoreboard queue of expected responses.
// Honours LSU_SUBWORD_EN to choose which accesses are expected to be legal.
// ---------------------------------------------------------------------------
module tb_lsu_memdados;

`ifdef LSU_SUBWORD_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        rd;
    logic        wr;
    logic [31:0] pos;
  } exp_t;

  logic clk;
  logic reset;
  logic preload;
  int   compared;
  int   mismatched;

  logic [31:0] mem    [64];
  logic [31:0] refMem [64];
  exp_t        sbQ [$];

  int          readCnt;
  int          writeCnt;
  int          bothCnt;
  int          dadosBadCnt;
  logic [31:0] lastPos;

  lsu_memdados_if bus ();

  lsu_memdados dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on the rising edge.
  assign bus.mem_saida = (bus.mem_posicao < 32'd64) ? mem[bus.mem_posicao[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (bus.mem_write && (bus.mem_posicao < 32'd64)) begin
      mem[bus.mem_posicao[5:0]] <= bus.mem_dados;
    end
  end

  // Strobe monitor, sampled away from the active edge.
  initial begin
    readCnt = 0; writeCnt = 0; bothCnt = 0; dadosBadCnt = 0; lastPos = 0;
  end

  always @(negedge clk) begin
    if (bus.mem_read)  readCnt++;
    if (bus.mem_write) writeCnt++;
    if (bus.mem_read && bus.mem_write) bothCnt++;
    if (!bus.mem_write && (bus.mem_dados != 32'h0)) dadosBadCnt++;
    if (bus.mem_read || bus.mem_write) lastPos = bus.mem_posicao;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model of one request: legality, latency, strobes, load data,
  // and the effect of a store on the reference memory.
  function automatic exp_t modelRequest(input logic wr, input logic [1:0] sz,
                                        input logic uns, input logic [31:0] addr,
                                        input logic [31:0] wd);
    exp_t        e;
    logic [31:0] word;
    logic [31:0] sh;
    logic [31:0] mask;
    logic [31:0] v;
    e.err = (sz == 2'b11) || (!SUB_EN && sz != 2'b10) ||
            (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00) ||
            ((addr >> 2) >= 32'd64);
    e.pos   = addr >> 2;
    e.rdata = 32'h0;
    e.rd    = 1'b0;
    e.wr    = 1'b0;
    e.lat   = 1;
    if (!e.err) begin
      word = refMem[e.pos[5:0]];
      sh   = 32'(addr[1:0]) * 8;
      mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      if (wr) begin
        e.wr  = 1'b1;
        e.rd  = (sz != 2'b10);
        e.lat = (sz == 2'b10) ? 2 : 3;
        refMem[e.pos[5:0]] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end else begin
        e.rd  = 1'b1;
        e.lat = 2;
        v = (word >> sh) & mask;
        if (!uns && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Drives one request, pushes its expectation, then waits for and checks
  // the response against the popped expectation.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   rd0, wr0, n, cnt;
    sbQ.push_back(modelRequest(wr, sz, uns, addr, wd));
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("req_ready before accept", 32'(bus.req_ready), 32'd1);
    rd0 = readCnt; wr0 = writeCnt;
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_write    = ~wr;
    bus.req_size     = ~sz;
    bus.req_unsigned = ~uns;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    cnt = 1;
    while (!bus.resp_valid && cnt < 10) begin
      @(posedge clk); #1; cnt++;
    end
    e = sbQ.pop_front();
    checkOutput("resp_valid seen", 32'(bus.resp_valid), 32'd1);
    checkOutput("latency", 32'(cnt), 32'(e.lat));
    checkOutput("resp_err", 32'(bus.resp_err), 32'(e.err));
    checkOutput("resp_rdata", bus.resp_rdata, e.rdata);
    checkOutput("mem_read used", 32'(readCnt != rd0), 32'(e.rd));
    checkOutput("mem_write used", 32'(writeCnt != wr0), 32'(e.wr));
    if (e.rd || e.wr) checkOutput("mem_posicao", lastPos, e.pos);
    if (e.wr) checkOutput("memory word", mem[e.pos[5:0]], refMem[e.pos[5:0]]);
    @(posedge clk); #1;
    checkOutput("resp pulse one cycle", 32'(bus.resp_valid), 32'd0);
    checkOutput("resp_rdata hold", bus.resp_rdata, e.rdata);
    checkOutput("resp_err hold", 32'(bus.resp_err), 32'(e.err));
  endtask

  // Accepts a request and pulses reset while its first strobe is active;
  // the request must vanish without a response or a memory write.
  task automatic abortRequest(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int n, respCnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!(bus.mem_read || bus.mem_write) && n < 5) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("strobe before abort", 32'(bus.mem_read || bus.mem_write), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mem_write during reset", 32'(bus.mem_write), 32'd0);
    checkOutput("mem_read during reset", 32'(bus.mem_read), 32'd0);
    #1 reset = 1'b0;
    respCnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) respCnt++;
    end
    checkOutput("no resp after abort", 32'(respCnt), 32'd0);
    checkOutput("req_ready after abort", 32'(bus.req_ready), 32'd1);
    checkOutput("aborted word intact", mem[addr[7:2]], refMem[addr[7:2]]);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    for (int i = 0; i < 64; i++) refMem[i] = 32'hA500_0000 | i;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    preload = 1'b1;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("reset mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("reset mem_write", 32'(bus.mem_write), 32'd0);
    checkOutput("reset mem_posicao", bus.mem_posicao, 32'h0);
    checkOutput("reset mem_dados", bus.mem_dados, 32'h0);
    preload = 1'b0;
    reset   = 1'b0;

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0000_0000);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0080);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_9ABC);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h20, 32'h1111_1111);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'hFC, 32'h0BAD_F00D);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    abortRequest(1'b1, 32'h8, 32'h1234_5678);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    abortRequest(1'b0, 32'h20, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 66) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), a, $urandom);
    end

    checkOutput("strobes never both high", 32'(bothCnt), 32'd0);
    checkOutput("mem_dados zero outside WRITE", 32'(dadosBadCnt), 32'd0);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
